// File: rtl/dac_channel_sequencer.sv
// dac_channel_sequencer
//   Multi-channel front end for the serial DAC driver. On a sweep request the
//   block snapshots the sample words, the channel-enable mask and the simul
//   flag, then issues one DAC write per enabled channel in ascending order.
//
// Ports
//   CLK, RST_N        clock (rising edge) and synchronous active-low reset
//   samples           CHANNELS packed words, channel i at [i*DATA_W +: DATA_W]
//   ch_enable         per-channel enable mask
//   start             request one sweep (only looked at in IDLE)
//   continuous        run sweeps back-to-back while high
//   simul             simultaneous-update command mode
//   dacdone           completion flag from the DAC driver
//   data/address/command  transfer payload, stable for the whole transfer
//   dactrig           transfer request to the driver
//   busy              high from LOAD until the block is back in IDLE
//   sweep_done        one-cycle pulse at the end of a complete sweep
//   timeout_err       one-cycle pulse when a sweep is aborted by timeout
//   dbg_state         current FSM state, for observation only
//
// Driver handshake: the payload is registered one cycle after TRIG entry and
// dactrig is then held high for TRIG_CYCLES cycles. The driver signals
// completion by taking dacdone high and later low; only a 1->0 transition of
// dacdone observed while in WAIT completes the transfer. Any other dacdone
// activity is ignored.
module dac_channel_sequencer #(
  parameter int CHANNELS       = 4,
  parameter int DATA_W         = 12,
  parameter int TRIG_CYCLES    = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [CHANNELS*DATA_W-1:0] samples,
  input  logic [CHANNELS-1:0]        ch_enable,
  input  logic                       start,
  input  logic                       continuous,
  input  logic                       simul,
  input  logic                       dacdone,
  output logic [DATA_W-1:0]          data,
  output logic [3:0]                 address,
  output logic [3:0]                 command,
  output logic                       dactrig,
  output logic                       busy,
  output logic                       sweep_done,
  output logic                       timeout_err,
  output logic [2:0]                 dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TRIG = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int MAX_TG  = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (TIMEOUT_CYCLES > MAX_TG) ? TIMEOUT_CYCLES : MAX_TG;
  localparam int CNT_W   = $clog2(MAX_CNT + 1) + 1;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          cur_ch;
  logic [CHANNELS-1:0] en_sh;
  logic [DATA_W-1:0]   samp_sh [CHANNELS];
  logic                simul_sh;
  logic                dacdone_q;

  logic [3:0]          first_ch;
  logic [3:0]          next_ch;
  logic                has_higher;
  logic [DATA_W-1:0]   cur_sample;
  logic                done_fall;
  logic                abort;
  logic                advance;

  // Lowest enabled channel of the live mask; used only at the LOAD edge,
  // which is the same edge the mask is captured.
  always_comb begin
    first_ch = 4'd0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ch_enable[i]) first_ch = 4'(i);
    end
  end

  // Next higher enabled channel in the shadow mask. The search never goes
  // past CHANNELS-1, so the last enabled channel ends the sweep.
  always_comb begin
    has_higher = 1'b0;
    next_ch    = cur_ch;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (en_sh[i] && (4'(i) > cur_ch)) begin
        has_higher = 1'b1;
        next_ch    = 4'(i);
      end
    end
  end

  always_comb begin
    cur_sample = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cur_ch == 4'(i)) cur_sample = samp_sh[i];
    end
  end

  assign done_fall = dacdone_q & ~dacdone;

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: if ((start || continuous) && (ch_enable != '0)) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_TRIG;
      S_TRIG: if (cnt == CNT_W'(TRIG_CYCLES)) state_nxt = S_WAIT;
      S_WAIT: begin
        // Completion wins over a timeout landing on the same cycle.
        if (done_fall) begin
          if (GAP_CYCLES != 0) begin
            state_nxt = S_GAP;
          end else if (has_higher) begin
            state_nxt = S_TRIG;
            advance   = 1'b1;
          end else begin
            state_nxt = S_DONE;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = S_IDLE;
          abort     = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          if (has_higher) begin
            state_nxt = S_TRIG;
            advance   = 1'b1;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (continuous && (ch_enable != '0)) state_nxt = S_LOAD;
        else                                 state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cur_ch      <= 4'd0;
      en_sh       <= '0;
      simul_sh    <= 1'b0;
      dacdone_q   <= 1'b0;
      data        <= '0;
      address     <= 4'd0;
      command     <= 4'd0;
      dactrig     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) samp_sh[i] <= '0;
    end else begin
      state       <= state_nxt;
      // One shared counter, restarted on every state change.
      cnt         <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      dacdone_q   <= dacdone;
      timeout_err <= abort;
      dactrig     <= (state == S_TRIG) && (cnt < CNT_W'(TRIG_CYCLES));

      if (state == S_LOAD) begin
        en_sh    <= ch_enable;
        simul_sh <= simul;
        cur_ch   <= first_ch;
        for (int i = 0; i < CHANNELS; i++) samp_sh[i] <= samples[i*DATA_W +: DATA_W];
      end

      if (advance) cur_ch <= next_ch;

      // Payload is latched once per transfer and then held until the next one.
      if ((state == S_TRIG) && (cnt == '0)) begin
        data    <= cur_sample;
        address <= cur_ch;
        if (!simul_sh)       command <= 4'b0011;
        else if (has_higher) command <= 4'b0000;
        else                 command <= 4'b0010;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign sweep_done = (state == S_DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_dac_channel_sequencer.sv
module tb_dac_channel_sequencer;

  localparam int CH   = 4;
  localparam int DW   = 12;
  localparam int TRIG = 2;
  localparam int GAP  = 2;
  localparam int TMO  = 16;
  localparam int EW   = 1 + 4 + 4 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [CH*DW-1:0]  samples;
  logic [CH-1:0]     ch_enable;
  logic              start, continuous, simul, dacdone;
  logic [DW-1:0]     data;
  logic [3:0]        address, command;
  logic              dactrig, busy, sweep_done, timeout_err;
  logic [2:0]        dbg_state;

  dac_channel_sequencer #(
    .CHANNELS(CH), .DATA_W(DW), .TRIG_CYCLES(TRIG), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .samples(samples), .ch_enable(ch_enable),
    .start(start), .continuous(continuous), .simul(simul), .dacdone(dacdone),
    .data(data), .address(address), .command(command), .dactrig(dactrig),
    .busy(busy), .sweep_done(sweep_done), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each expected transfer is {first_of_sweep, address, command, data}.
  logic [EW-1:0] exp_q[$];

  task automatic push_sweep(input logic [CH*DW-1:0] s, input logic [CH-1:0] m, input logic sim);
    int   hi;
    logic first;
    logic [3:0] cmd;
    hi = -1;
    for (int i = 0; i < CH; i++) if (m[i]) hi = i;
    first = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (m[i]) begin
        if (!sim)        cmd = 4'b0011;
        else if (i == hi) cmd = 4'b0010;
        else             cmd = 4'b0000;
        exp_q.push_back({first, 4'(i), cmd, s[i*DW +: DW]});
        first = 1'b0;
      end
    end
  endtask

  // ---------------- DAC driver model ----------------
  logic drv_hang = 1'b0;
  logic drv_prev = 1'b0;
  int   drv_dmin = 2;
  int   drv_dmax = 12;
  int   drop_cyc = 0;

  initial begin
    int d;
    dacdone = 1'b0;
    forever begin
      @(negedge clk);
      if (dactrig && !drv_prev && !drv_hang) begin
        dacdone = 1'b1;
        d = $urandom_range(drv_dmax, drv_dmin);
        repeat (d) @(negedge clk);
        dacdone  = 1'b0;
        drop_cyc = cyc;
      end
      drv_prev = dactrig;
    end
  end

  // ---------------- transfer monitor ----------------
  logic          mon_prev = 1'b0;
  int            mon_width = 0;
  int            n_sweeps = 0;
  int            n_rises = 0;
  logic [DW-1:0] cap_data;
  logic [3:0]    cap_addr, cap_cmd;
  logic [EW-1:0] e;

  always @(negedge clk) begin
    if (sweep_done) n_sweeps++;
    if (dactrig && !mon_prev) begin
      n_rises++;
      check("xfer_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("xfer_addr", address, e[EW-2 -: 4]);
        check("xfer_cmd",  command, e[EW-6 -: 4]);
        check("xfer_data", data,    e[DW-1:0]);
        if (!e[EW-1]) check("gap_latency", cyc - drop_cyc, GAP + 2);
      end
      cap_data  = data;
      cap_addr  = address;
      cap_cmd   = command;
      mon_width = 1;
    end else if (dactrig) begin
      mon_width++;
      check("hold_payload", {cap_data, cap_addr, cap_cmd} == {data, address, command}, 1);
    end else if (mon_prev) begin
      check("trig_width", mon_width, TRIG);
    end
    mon_prev = dactrig;
  end

  // ---------------- driver tasks ----------------
  task automatic randomize_inputs();
    samples   = {$urandom, $urandom};
    ch_enable = CH'($urandom_range(15, 1));
    simul     = 1'($urandom_range(1, 0));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_sweep_done(input string tag, input int budget);
    int   k;
    logic seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      if (sweep_done) seen = 1'b1;
      k++;
    end
    check({tag, "_sweep_done_seen"}, seen, 1);
  endtask

  task automatic wait_trig(input string tag, input int budget);
    int   k;
    logic seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      if (dactrig) seen = 1'b1;
      k++;
    end
    check({tag, "_dactrig_seen"}, seen, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},        data, 0);
    check({tag, "_address"},     address, 0);
    check({tag, "_command"},     command, 0);
    check({tag, "_dactrig"},     dactrig, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_sweep_done"},  sweep_done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic single_sweep(input string tag);
    int s0;
    s0 = n_sweeps;
    push_sweep(samples, ch_enable, simul);
    pulse_start();
    wait_sweep_done(tag, 400);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_sweep_count"}, n_sweeps - s0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0, s0, r0, t_rise, k;
    logic seen, any_busy, any_trig;

    rst_n = 1'b0; samples = '0; ch_enable = '0;
    start = 1'b0; continuous = 1'b0; simul = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All four channels, per-channel update, with start-latency checks.
    samples = {$urandom, $urandom};
    ch_enable = 4'b1111;
    simul = 1'b0;
    s0 = n_sweeps;
    push_sweep(samples, ch_enable, simul);
    pulse_start();
    c0 = cyc;
    check("busy_with_load", busy, 1);
    @(negedge clk);
    check("trig_not_yet", dactrig, 0);
    @(negedge clk);
    check("trig_latency", dactrig, 1);
    check("trig_edge_index", cyc - c0, 2);
    wait_sweep_done("all4", 400);
    @(negedge clk);
    check("all4_busy_after", busy, 0);
    check("all4_queue_empty", exp_q.size(), 0);
    check("all4_sweep_count", n_sweeps - s0, 1);

    // Sparse mask, simultaneous update.
    samples = {$urandom, $urandom};
    samples[1*DW +: DW] = 12'h5F3;
    samples[3*DW +: DW] = 12'h3F5;
    ch_enable = 4'b1010;
    simul = 1'b1;
    single_sweep("sparse");

    // Random single sweeps.
    for (int i = 0; i < 6; i++) begin
      randomize_inputs();
      single_sweep("rand");
    end

    // Snapshot integrity: inputs change the cycle after LOAD.
    randomize_inputs();
    push_sweep(samples, ch_enable, simul);
    pulse_start();
    @(negedge clk);
    randomize_inputs();
    wait_sweep_done("snapshot", 400);
    @(negedge clk);
    check("snapshot_queue_empty", exp_q.size(), 0);

    // Continuous: three sweeps, fresh snapshot at each LOAD.
    repeat (3) @(negedge clk);
    s0 = n_sweeps;
    randomize_inputs();
    push_sweep(samples, ch_enable, simul);
    continuous = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_sweep_done("cont", 400);
      randomize_inputs();
      push_sweep(samples, ch_enable, simul);
    end
    r0 = n_rises;
    k = 0;
    while (n_rises == r0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("cont_third_started", n_rises - r0, 1);
    continuous = 1'b0;
    wait_sweep_done("cont_last", 400);
    randomize_inputs();
    @(negedge clk);
    check("cont_busy_after", busy, 0);
    repeat (30) @(negedge clk);
    check("cont_sweep_count", n_sweeps - s0, 3);
    check("cont_queue_empty", exp_q.size(), 0);

    // Timeout: driver never answers.
    drv_hang = 1'b1;
    randomize_inputs();
    s0 = n_sweeps;
    push_sweep(samples, ch_enable, simul);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    pulse_start();
    wait_trig("timeout", 10);
    t_rise = cyc;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk);
      if (timeout_err) seen = 1'b1;
      k++;
    end
    check("timeout_seen", seen, 1);
    check("timeout_latency", cyc - t_rise, TRIG + TMO);
    check("timeout_busy_low", busy, 0);
    @(negedge clk);
    check("timeout_pulse_width", timeout_err, 0);
    check("timeout_dactrig_low", dactrig, 0);
    check("timeout_no_sweep_done", n_sweeps - s0, 0);
    drv_hang = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of WAIT.
    drv_dmin = 12;
    drv_dmax = 12;
    randomize_inputs();
    push_sweep(samples, ch_enable, simul);
    pulse_start();
    wait_trig("midwait", 10);
    repeat (TRIG + 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midwait_reset");
    exp_q.delete();
    rst_n = 1'b1;
    drv_dmin = 2;
    drv_dmax = 12;
    repeat (20) @(negedge clk);
    check("midwait_no_resume", busy, 0);

    // Zero mask: start and continuous are ignored.
    ch_enable = '0;
    start = 1'b1;
    continuous = 1'b1;
    any_busy = 1'b0;
    any_trig = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 2) begin
        start = 1'b0;
        continuous = 1'b0;
      end
      any_busy |= busy;
      any_trig |= dactrig;
    end
    check("mask0_busy", any_busy, 0);
    check("mask0_dactrig", any_trig, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed no end expected end");
    $fatal(1, "watchdog");
  end

endmodule
